// File: rtl/fir_seq_pkg.sv
// Shared types and sizing for the fp16 FIR tap sequencer.
package fir_seq_pkg;

  localparam int FIR_NTAPS = 64;
  localparam int FIR_AW    = 6;
  localparam int FP16_W    = 16;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2
  } fir_seq_state_t;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample delay line: one synchronous write port, one combinational
// read port. Contents are never reset; the sequencer zeroes them explicitly.
module fir_delay_line
  import fir_seq_pkg::*;
#(
  parameter int NTAPS = FIR_NTAPS,
  parameter int AW    = FIR_AW,
  parameter int DW    = FP16_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [NTAPS];

  // Sample storage: single write per cycle, data path only, no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for the 64-tap fp16 FIR: accepts one sample per burst, walks
// the coefficient address space and streams (coefficient, delayed sample)
// pairs with first/last framing to the MAC.
module fir_tap_sequencer
  import fir_seq_pkg::*;
#(
  parameter int NTAPS = FIR_NTAPS,
  parameter int AW    = FIR_AW,
  parameter int DW    = FP16_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [AW-1:0] cmem_addr,
  input  logic [DW-1:0] cmem_q,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_coef,
  output logic [DW-1:0] op_sample,
  output logic          op_first,
  output logic          op_last,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);

  fir_seq_state_t state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  k_q, k_d;
  logic [AW-1:0]  clr_idx_q, clr_idx_d;

  logic           dl_we;
  logic [AW-1:0]  dl_waddr;
  logic [DW-1:0]  dl_wdata;
  logic [AW-1:0]  dl_raddr;
  logic [DW-1:0]  dl_rdata;

  // Control state: FSM, tap counter, clear index and write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      wr_ptr_q  <= '0;
      k_q       <= '0;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      k_q       <= k_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state, delay-line write control and handshake outputs; clr overrides all.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    k_d       = k_q;
    clr_idx_d = clr_idx_q;
    dl_we     = 1'b0;
    dl_waddr  = wr_ptr_q;
    dl_wdata  = in_data;
    in_ready  = 1'b0;
    op_valid  = 1'b0;
    op_first  = 1'b0;
    op_last   = 1'b0;

    unique case (state_q)
      CLEAR: begin
        dl_we    = 1'b1;
        dl_waddr = clr_idx_q;
        dl_wdata = '0;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          clr_idx_d = '0;
          wr_ptr_d  = '0;
        end else begin
          clr_idx_d = clr_idx_q + ONE;
        end
      end
      IDLE: begin
        in_ready = !clr;
        if (in_valid && !clr) begin
          dl_we   = 1'b1;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        op_valid = 1'b1;
        op_first = (k_q == '0);
        op_last  = (k_q == LAST_IDX);
        if (op_ready) begin
          k_d = k_q + ONE;
          if (k_q == LAST_IDX) begin
            wr_ptr_d = wr_ptr_q + ONE;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    // A clear request aborts whatever is in flight and restarts the sweep at 0.
    if (clr) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end
  end

  // Newest sample sits at wr_ptr; tap k reads k samples back, wrapping mod NTAPS.
  assign dl_raddr  = wr_ptr_q - k_q;
  assign cmem_addr = k_q;
  assign op_coef   = cmem_q;
  assign op_sample = dl_rdata;
  assign busy      = (state_q != IDLE);

  fir_delay_line #(
    .NTAPS (NTAPS),
    .AW    (AW),
    .DW    (DW)
  ) u_delay_line (
    .clk   (clk),
    .we    (dl_we),
    .waddr (dl_waddr),
    .wdata (dl_wdata),
    .raddr (dl_raddr),
    .rdata (dl_rdata)
  );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: stimulus pushes one expected pair per
// tap when a sample is offered; a negedge monitor pops on every MAC handshake.
module tb_fir_tap_sequencer;

  localparam int NT = 64;

  typedef struct packed {
    logic        first;
    logic        last;
    logic [15:0] coef;
    logic [15:0] samp;
    logic [5:0]  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [5:0]  cmem_addr;
  logic [15:0] cmem_q;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [15:0] op_coef;
  logic [15:0] op_sample;
  logic        op_first;
  logic        op_last;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  logic [15:0] hist [0:255];
  int          nsamp = -1;
  logic        bp_en = 1'b0;
  int          cnt;

  always #5 clk = ~clk;

  fir_tap_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cmem_addr (cmem_addr),
    .cmem_q    (cmem_q),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_coef   (op_coef),
    .op_sample (op_sample),
    .op_first  (op_first),
    .op_last   (op_last),
    .busy      (busy)
  );

  // Coefficient ROM model; taps 1 and 63 carry the known test values.
  function automatic logic [15:0] coef(input logic [5:0] a);
    logic [15:0] r;
    case (a)
      6'd1:    r = 16'h8114;
      6'd63:   r = 16'h80DC;
      default: r = {2'b01, 4'h5, a, 4'h3};
    endcase
    return r;
  endfunction

  assign cmem_q = coef(cmem_addr);

  // Small non-negative integer to its fp16 bit pattern.
  function automatic logic [15:0] fp16_int(input int i);
    int e;
    logic [15:0] r;
    if (i == 0) return 16'h0000;
    e = 0;
    while ((i >> (e + 1)) != 0) e++;
    r = '0;
    r[14:10] = 5'(e + 15);
    r[9:0]   = 10'((i << (10 - e)) & 32'h3FF);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    nsamp = -1;
  endtask

  // Record the new sample and queue the 64 pairs its burst must produce.
  task automatic push_burst(input logic [15:0] d);
    exp_t e;
    nsamp++;
    hist[nsamp] = d;
    for (int k = 0; k < NT; k++) begin
      e.first = (k == 0);
      e.last  = (k == NT - 1);
      e.coef  = coef(6'(k));
      e.samp  = (nsamp - k >= 0) ? hist[nsamp - k] : 16'h0000;
      e.addr  = 6'(k);
      sb.push_back(e);
    end
  endtask

  task automatic send_sample(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 after %0d cycles, expected 1", n);
    end else begin
      push_burst(d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic count_not_ready(output int n);
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Backpressure driver: random op_ready when enabled, otherwise always ready.
  initial begin
    forever begin
      @(posedge clk); #1;
      op_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pop on each handshake; stalled pairs must hold every field.
  exp_t e_m, got_m, prev_m;
  logic stall_prev = 1'b0;
  always @(negedge clk) begin
    got_m = {op_first, op_last, op_coef, op_sample, cmem_addr};
    if (rst_n && op_valid && stall_prev) begin
      n_checks++;
      if (got_m !== prev_m) begin
        n_fail++;
        $display("FAIL stall_hold: got %h, expected held %h", got_m, prev_m);
      end
    end
    if (rst_n && op_valid && op_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pair: got addr=%0d sample=%h, expected no pair", cmem_addr, op_sample);
      end else begin
        e_m = sb.pop_front();
        if (got_m !== e_m) begin
          n_fail++;
          $display("FAIL pair: got first=%0b last=%0b addr=%0d coef=%h sample=%h, expected first=%0b last=%0b addr=%0d coef=%h sample=%h",
                   op_first, op_last, cmem_addr, op_coef, op_sample,
                   e_m.first, e_m.last, e_m.addr, e_m.coef, e_m.samp);
        end
      end
    end
    stall_prev = rst_n && op_valid && !op_ready;
    prev_m     = got_m;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with in_valid already high.
    in_valid = 1'b1;
    in_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_op_first", 32'(op_first), 32'd0);
    chk("rst_op_last",  32'(op_last),  32'd0);
    chk("rst_cmem_addr", 32'(cmem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    count_not_ready(cnt);
    chk("reset_to_ready", 32'(cnt), 32'd64);
    send_sample(16'h0000);

    // Impulse: 3C00 then 63 zeros.
    send_sample(16'h3C00);
    for (int i = 0; i < 63; i++) send_sample(16'h0000);
    wait_drain();

    // Backpressure bursts.
    bp_en = 1'b1;
    send_sample(16'h4000);
    send_sample(16'h4200);
    send_sample(16'hC500);
    wait_drain();
    bp_en = 1'b0;

    // Reset in the middle of a burst.
    send_sample(16'h4400);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_op_valid", 32'(op_valid), 32'd0);
    chk("midrst_cmem_addr", 32'(cmem_addr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    sb.delete();
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_not_ready(cnt);
    chk("midrst_to_ready", 32'(cnt), 32'd64);

    // clr at tap 20.
    send_sample(16'h4200);
    cnt = 0;
    while (!(op_valid && cmem_addr == 6'd20) && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("reach_tap20", 32'(cmem_addr), 32'd20);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_op_valid", 32'(op_valid), 32'd0);
    chk("clr_op_last", 32'(op_last), 32'd0);
    sb.delete();
    model_clear();
    count_not_ready(cnt);
    chk("clr_to_ready", 32'(cnt), 32'd64);
    send_sample(16'h4500);
    wait_drain();

    // clr and input in the same IDLE cycle.
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    #1;
    chk("simul_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("simul_busy", 32'(busy), 32'd1);
    chk("simul_op_valid", 32'(op_valid), 32'd0);
    model_clear();
    count_not_ready(cnt);
    chk("simul_to_ready", 32'(cnt), 32'd64);

    // Wrap-around: 70 integer samples.
    for (int i = 0; i < 70; i++) send_sample(fp16_int(i));
    wait_drain();

    repeat (5) @(posedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
